wb_dma: RTL

//  Wishbone bus initiator that copies a block of words from a source to a destination address.
//  It is a second bus master beside the cpu on the intercon, and it issues classic single reads and writes to rom/ram/uart.

---
 rtl/wb_dma.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_dma.sv
// Wishbone block-copy initiator: reads a word from src, writes it to dst, repeats len times.
// Latency: bus strobe one cycle after an accepted start; 4 cycles per word with single-cycle acks.
// Backpressure: each access holds cyc/stb/adr until ack, err or the wait-counter timeout.
module wb_dma #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int SEL_WIDTH = 4,
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADR_WIDTH-1:0] src_adr_i,
    input  logic [ADR_WIDTH-1:0] dst_adr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 dma_cyc_o,
    output logic                 dma_stb_o,
    output logic                 dma_we_o,
    output logic [SEL_WIDTH-1:0] dma_sel_o,
    output logic [ADR_WIDTH-1:0] dma_adr_o,
    output logic [DAT_WIDTH-1:0] dma_dat_o,
    input  logic [DAT_WIDTH-1:0] dma_dat_i,
    input  logic                 dma_ack_i,
    input  logic                 dma_err_i
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP} state_t;

    state_t               state, state_d;
    logic [ADR_WIDTH-1:0] src_ptr, src_d, dst_ptr, dst_d, adr_d;
    logic [LEN_WIDTH-1:0] cnt, cnt_d;
    logic [TW-1:0]        wait_cnt, wait_d;
    logic [DAT_WIDTH-1:0] dat_d;
    logic                 done_d, err_d, stb_d, we_d, stb_q;
    logic                 abort, timeout_hit;

    // Abort on the cycle the counter would reach TIMEOUT, so stb is high for exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state;
        src_d   = src_ptr;
        dst_d   = dst_ptr;
        cnt_d   = cnt;
        wait_d  = wait_cnt;
        dat_d   = dma_dat_o;
        done_d  = 1'b0;
        err_d   = err_o;
        abort   = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d   = src_adr_i;
                        dst_d   = dst_adr_i;
                        cnt_d   = len_i;
                        wait_d  = '0;
                        state_d = RD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (dma_err_i) begin
                    abort = 1'b1;
                end else if (dma_ack_i) begin
                    dat_d   = dma_dat_i;
                    src_d   = src_ptr + ADR_WIDTH'(SEL_WIDTH);
                    state_d = RGAP;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            RGAP: begin
                wait_d  = '0;
                state_d = WR;
            end
            WR: begin
                if (dma_err_i) begin
                    abort = 1'b1;
                end else if (dma_ack_i) begin
                    dst_d = dst_ptr + ADR_WIDTH'(SEL_WIDTH);
                    cnt_d = cnt - 1'b1;
                    if (cnt == LEN_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WGAP;
                    end
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            WGAP: begin
                wait_d  = '0;
                state_d = RD;
            end
            default: state_d = IDLE;
        endcase

        // Pointers and count keep their pre-abort values.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end

        stb_d = (state_d == RD) || (state_d == WR);
        we_d  = (state_d == WR);
        if (state_d == RD)
            adr_d = src_d;
        else if (state_d == WR)
            adr_d = dst_d;
        else
            adr_d = dma_adr_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            cnt       <= '0;
            wait_cnt  <= '0;
            stb_q     <= 1'b0;
            dma_we_o  <= 1'b0;
            dma_sel_o <= '0;
            dma_adr_o <= '0;
            dma_dat_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_d;
            src_ptr   <= src_d;
            dst_ptr   <= dst_d;
            cnt       <= cnt_d;
            wait_cnt  <= wait_d;
            stb_q     <= stb_d;
            dma_we_o  <= we_d;
            dma_sel_o <= stb_d ? '1 : '0;
            dma_adr_o <= adr_d;
            dma_dat_o <= dat_d;
            busy_o    <= (state_d != IDLE);
            done_o    <= done_d;
            err_o     <= err_d;
        end
    end

    assign dma_cyc_o = stb_q;
    assign dma_stb_o = stb_q;

endmodule
